// File: rtl/ctl_round.sv
// Round/game-flow controller: sequences intro, duck spawns, shot results and round
// progression, and gates the trigger stage through lock_o.
module ctl_round #(
  parameter int SHOTS_PER_DUCK  = 3,
  parameter int DUCKS_PER_ROUND = 10,
  parameter int HITS_TO_PASS    = 6,
  parameter int POINTS_PER_HIT  = 100,
  parameter int INTRO_FRAMES    = 120,
  parameter int ACTIVE_FRAMES   = 300,
  parameter int PAUSE_FRAMES    = 60,
  parameter int RESULT_TIMEOUT  = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        new_frame_i,
  input  logic        start_i,
  input  logic        shot_fired_i,
  input  logic        hit_i,
  input  logic        miss_i,
  output logic        lock_o,
  output logic        duck_spawn_o,
  output logic [1:0]  duck_state_o,
  output logic [1:0]  ammo_o,
  output logic [3:0]  duck_idx_o,
  output logic [3:0]  hit_count_o,
  output logic [7:0]  round_o,
  output logic [15:0] score_o,
  output logic        game_over_o
);
  typedef enum logic [3:0] {
    S_IDLE, S_INTRO, S_SPAWN, S_ACTIVE, S_WAIT, S_FALL, S_ESCAPE, S_REND, S_OVER
  } state_t;

  localparam logic [9:0]  INTRO_LAST  = 10'(INTRO_FRAMES - 1);
  localparam logic [9:0]  ACTIVE_LAST = 10'(ACTIVE_FRAMES - 1);
  localparam logic [9:0]  PAUSE_LAST  = 10'(PAUSE_FRAMES - 1);
  localparam logic [9:0]  RES_LAST    = 10'(RESULT_TIMEOUT - 1);
  localparam logic [1:0]  AMMO_FULL   = 2'(SHOTS_PER_DUCK);
  localparam logic [3:0]  LAST_DUCK   = 4'(DUCKS_PER_ROUND - 1);
  localparam logic [3:0]  PASS_HITS   = 4'(HITS_TO_PASS);
  localparam logic [16:0] PTS         = 17'(POINTS_PER_HIT);

  state_t      state_q, state_d;
  logic [9:0]  frm_q, frm_d;      // pause counter, cleared on every state entry
  logic [9:0]  fly_q, fly_d;      // flight timer, advances only in ACTIVE
  logic [1:0]  ammo_q, ammo_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  hits_q, hits_d;
  logic [7:0]  round_q, round_d;
  logic [15:0] score_q, score_d;
  logic        lock_q, lock_d, spawn_q, spawn_d, over_q, over_d;
  logic [1:0]  dstate_q, dstate_d;
  logic [16:0] score_sum;

  assign score_sum = {1'b0, score_q} + PTS;

  always_comb begin
    state_d = state_q;
    fly_d   = fly_q;
    ammo_d  = ammo_q;
    idx_d   = idx_q;
    hits_d  = hits_q;
    round_d = round_q;
    score_d = score_q;
    case (state_q)
      S_IDLE, S_OVER: if (start_i) begin
        state_d = S_INTRO;
        score_d = '0;
        round_d = 8'd1;
        hits_d  = '0;
        idx_d   = '0;
      end
      S_INTRO: if (new_frame_i && frm_q == INTRO_LAST) state_d = S_SPAWN;
      S_SPAWN: state_d = S_ACTIVE;
      S_ACTIVE: begin
        fly_d = fly_q + 10'(new_frame_i);
        // escape takes priority over a shot landing on the final flight frame
        if (new_frame_i && fly_q == ACTIVE_LAST) state_d = S_ESCAPE;
        else if (shot_fired_i) begin
          ammo_d  = ammo_q - 2'd1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (hit_i) begin
          state_d = S_FALL;
          score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
          hits_d  = hits_q + 4'd1;
        end else if (miss_i || (new_frame_i && frm_q == RES_LAST)) begin
          state_d = (ammo_q == 2'd0) ? S_ESCAPE : S_ACTIVE;
        end
      end
      S_FALL, S_ESCAPE: if (new_frame_i && frm_q == PAUSE_LAST) begin
        if (idx_q == LAST_DUCK) state_d = S_REND;
        else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_SPAWN;
        end
      end
      S_REND: if (new_frame_i && frm_q == PAUSE_LAST) begin
        if (hits_q >= PASS_HITS) begin
          state_d = S_INTRO;
          round_d = (round_q == 8'hFF) ? round_q : round_q + 8'd1;
          hits_d  = '0;
          idx_d   = '0;
        end else state_d = S_OVER;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_SPAWN) begin
      ammo_d = AMMO_FULL;
      fly_d  = '0;
    end
    frm_d = (state_d != state_q) ? '0 : frm_q + 10'(new_frame_i);

    // outputs are decoded from the next state so they register alongside it
    lock_d  = (state_d != S_ACTIVE);
    spawn_d = (state_d == S_SPAWN);
    over_d  = (state_d == S_OVER);
    case (state_d)
      S_ACTIVE, S_WAIT: dstate_d = 2'd1;
      S_FALL:           dstate_d = 2'd2;
      S_ESCAPE:         dstate_d = 2'd3;
      default:          dstate_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      frm_q    <= '0;
      fly_q    <= '0;
      ammo_q   <= '0;
      idx_q    <= '0;
      hits_q   <= '0;
      round_q  <= '0;
      score_q  <= '0;
      lock_q   <= 1'b1;
      spawn_q  <= 1'b0;
      over_q   <= 1'b0;
      dstate_q <= '0;
    end else begin
      state_q  <= state_d;
      frm_q    <= frm_d;
      fly_q    <= fly_d;
      ammo_q   <= ammo_d;
      idx_q    <= idx_d;
      hits_q   <= hits_d;
      round_q  <= round_d;
      score_q  <= score_d;
      lock_q   <= lock_d;
      spawn_q  <= spawn_d;
      over_q   <= over_d;
      dstate_q <= dstate_d;
    end
  end

  assign lock_o       = lock_q;
  assign duck_spawn_o = spawn_q;
  assign duck_state_o = dstate_q;
  assign ammo_o       = ammo_q;
  assign duck_idx_o   = idx_q;
  assign hit_count_o  = hits_q;
  assign round_o      = round_q;
  assign score_o      = score_q;
  assign game_over_o  = over_q;
endmodule
